// File: rtl/add_1bit_pkg.sv
// add_1bit_pkg: shared types for the 1-bit full-adder slice.
// res_t bundles the four per-bit outputs; helpers build it.
package add_1bit_pkg;

  typedef struct packed {
    logic sum;
    logic cout;
    logic gen;
    logic prop;
  } res_t;

  function automatic int add_latency(bit registered);
    return registered ? 1 : 0;
  endfunction

  function automatic res_t pack_res(
    logic s,
    logic c,
    logic g,
    logic p
  );
    res_t r;
    r.sum  = s;
    r.cout = c;
    r.gen  = g;
    r.prop = p;
    return r;
  endfunction

endpackage

// File: rtl/add_1bit_if.sv
// add_1bit_if: operand beat (in_valid,a,b,cin) in,
// result beat (out_valid,sum,cout,gen,prop) out.
interface add_1bit_if;

  logic in_valid;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;
  logic gen;
  logic prop;
  logic out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, gen, prop, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, gen, prop, out_valid
  );

endinterface

// File: rtl/add_1bit_half_add.sv
// half_add: s = a ^ b, c = a & b.
// Ports: a, b in; s, c out.
module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/add_1bit.sv
// add_1bit: full-adder slice with gen/prop, optional output reg.
// Ports: clk, rst_n (async low), io (add_1bit_if.slave).
module add_1bit
  import add_1bit_pkg::*;
#(
  parameter bit REGISTERED = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  add_1bit_if.slave io
);

  logic p;
  logic g;
  logic s;
  logic c2;
  res_t r;

  half_add u_ha1 (
    .a (io.a),
    .b (io.b),
    .s (p),
    .c (g)
  );

  half_add u_ha2 (
    .a (p),
    .b (io.cin),
    .s (s),
    .c (c2)
  );

  assign r = pack_res(s, g | c2, g, p);

  generate
    if (REGISTERED) begin : g_reg
      res_t q;
      logic v;

      // data holds on idle beats; only valid drops
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
          v <= 1'b0;
        end else begin
          v <= io.in_valid;
          if (io.in_valid) begin
            q <= r;
          end
        end
      end

      assign io.sum       = q.sum;
      assign io.cout      = q.cout;
      assign io.gen       = q.gen;
      assign io.prop      = q.prop;
      assign io.out_valid = v;
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk   = clk ^ rst_n;

      assign io.sum       = r.sum;
      assign io.cout      = r.cout;
      assign io.gen       = r.gen;
      assign io.prop      = r.prop;
      assign io.out_valid = io.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_add_1bit.sv
// tb_add_1bit: scoreboard bench, registered and comb slices.
// Expected beats queued at drive, popped one edge later.
module tb_add_1bit;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  logic [3:0] held = 4'b0;

  always #5 clk = ~clk;

  add_1bit_if ifr ();
  add_1bit_if ifc ();

  add_1bit #(.REGISTERED(1'b1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifr)
  );

  add_1bit #(.REGISTERED(1'b0)) u_cmb (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  // {sum,cout,gen,prop} from plain arithmetic
  function automatic logic [3:0] mdl(
    logic a,
    logic b,
    logic c
  );
    logic [1:0] t;
    t = {1'b0, a} + {1'b0, b} + {1'b0, c};
    return {t[0], t[1], a & b, a ^ b};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [4:0] got,
    input logic [4:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] rd_reg();
    return {ifr.out_valid, ifr.sum, ifr.cout,
            ifr.gen, ifr.prop};
  endfunction

  function automatic logic [4:0] rd_cmb();
    return {ifc.out_valid, ifc.sum, ifc.cout,
            ifc.gen, ifc.prop};
  endfunction

  task automatic drive(
    input string tag,
    input logic  v,
    input logic  a,
    input logic  b,
    input logic  c
  );
    exp_t e;
    @(negedge clk);
    ifr.in_valid = v;
    ifr.a        = a;
    ifr.b        = b;
    ifr.cin      = c;
    ifc.in_valid = v;
    ifc.a        = a;
    ifc.b        = b;
    ifc.cin      = c;
    if (v) held = mdl(a, b, c);
    e.v = v;
    e.d = held;
    sbq.push_back(e);
    #1;
    chk({tag, "_comb"}, rd_cmb(), {v, mdl(a, b, c)});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, rd_reg(), 5'bxxxxx);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_reg"}, rd_reg(), {e.v, e.d});
    end
  endtask

  initial begin
    logic [2:0] k;
    ifr.in_valid = 1'b0;
    ifr.a        = 1'b0;
    ifr.b        = 1'b0;
    ifr.cin      = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.a        = 1'b0;
    ifc.b        = 1'b0;
    ifc.cin      = 1'b0;
    #1;
    chk("reset_state", rd_reg(), 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      drive("sweep", 1'b1, k[2], k[1], k[0]);
    end

    drive("hold_load", 1'b1, 1'b1, 1'b1, 1'b1);
    drive("hold_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    drive("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", rd_reg(), 5'b0);
    sbq.delete();
    held = 4'b0;
    @(posedge clk);
    #1;
    chk("rst_held", rd_reg(), 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("post_rst", 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      drive("rand",
            ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_1bit.md
Name: add_1bit

Overview:
- 1-bit full adder cell for the Y-86 pipeline ALU add/sub datapath; replicated bit-slice for ripple/lookahead adders.
- Computes sum and carry-out of a, b, cin; also exports generate/propagate for carry-lookahead use.
- Optional output register stage with valid flag, so the cell can sit at a pipeline boundary; combinational mode available for ripple chains.

Parameters:
- REGISTERED, 1, 1 = outputs registered (latency 1 cycle); 0 = outputs purely combinational (latency 0, clk/rst_n unused for data).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a/b/cin this cycle
- a  input  1  operand bit A
- b  input  1  operand bit B
- cin  input  1  carry-in
- sum  output  1  a XOR b XOR cin
- cout  output  1  carry-out
- gen  output  1  generate = a AND b
- prop  output  1  propagate = a XOR b
- out_valid  output  1  qualifies sum/cout/gen/prop

Behaviour:
- Arithmetic: sum = a^b^cin; cout = (a&b) | (cin&(a^b)); gen = a&b; prop = a^b. Equivalent to {cout,sum} = a+b+cin (2-bit result).
- Full truth table required: 000->s0 c0; 001->s1 c0; 010->s1 c0; 011->s0 c1; 100->s1 c0; 101->s0 c1; 110->s0 c1; 111->s1 c1 (order a,b,cin).
- Core built as two half adders plus OR: HA1(a,b) -> p,g; HA2(p,cin) -> sum,c2; cout = g|c2.
- REGISTERED=1: on each rising clk, sum/cout/gen/prop/out_valid load the combinational results and in_valid; latency exactly 1 cycle, throughput 1 per cycle.
- Registered data updates only when in_valid=1; when in_valid=0, data registers hold previous values and out_valid goes 0 next cycle.
- REGISTERED=0: outputs follow inputs combinationally; out_valid = in_valid; no state.
- Reset (REGISTERED=1): rst_n low forces sum, cout, gen, prop, out_valid to 0 immediately, independent of clk; held while low.
- Reset release: first capture occurs at first rising clk with rst_n high; deassertion coincident with clk edge must not capture (synchronise release externally).
- Reset mid-stream: in-flight result discarded; out_valid 0 until a new in_valid beat is captured.
- No X propagation tolerated: any X on inputs with in_valid=1 is a bench error; outputs never X after reset.

Decomposition:
- Shared package (alu_pkg): none mandatory; optional constant ADD_LATENCY = REGISTERED.
- One sub-module: half_add (a, b -> s = a^b, c = a&b), instantiated twice.
- Register stage in a single always block with async reset, generated under REGISTERED.

Test Plan:
- Exhaustive sweep, REGISTERED=0: all 8 (a,b,cin) combos, 5 ns apart -> sum/cout match truth table, e.g. 011 -> sum 0 cout 1, 111 -> sum 1 cout 1; gen/prop match, e.g. 110 -> gen 1 prop 0.
- Exhaustive sweep, REGISTERED=1, in_valid=1 every cycle: result for input at edge N appears after edge N, e.g. 101 -> sum 0 cout 1 one cycle later; out_valid high from second edge on.
- Hold: apply 111 valid, then in_valid=0 with inputs 000 -> sum 1 cout 1 held, out_valid drops to 0.
- Async reset: after 111 captured, pull rst_n low between edges -> sum, cout, gen, prop, out_valid read 0 before next clk edge.
- Reset release: release rst_n, apply 001 valid -> next edge sum 1 cout 0 out_valid 1.
- Random 1000 beats vs reference model a+b+cin -> zero mismatches.
